// File: rtl/branch_resolve_unit.sv
// Branch resolution queue: holds in-flight predictions from fetch, retires the oldest
// on EX resolution, flags mispredicts with redirect/history repair, and emits table training.
module branch_resolve_unit #(
  parameter int GHR_W = 8,
  parameter int PC_W  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_valid,
  input  logic             pred_taken,
  input  logic [PC_W-1:0]  pred_pc,
  input  logic [PC_W-1:0]  pred_target,
  input  logic [GHR_W-1:0] pred_ghr,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [PC_W-1:0]  res_target,
  output logic             stall,
  output logic             mispredict,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [GHR_W-1:0] restore_ghr,
  output logic             upd_valid,
  output logic [GHR_W-1:0] upd_index,
  output logic             upd_taken,
  output logic             underflow,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             taken;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  target;
    logic [GHR_W-1:0] ghr;
  } entry_t;

  entry_t           queue_mem [DEPTH];
  entry_t           head;
  entry_t           push_entry;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [OCC_W-1:0] occupancy;
  logic             empty;
  logic             full;
  logic             resolve;
  logic             miss;
  logic             push;

  assign head       = queue_mem[rd_ptr];
  assign push_entry = '{taken: pred_taken, pc: pred_pc, target: pred_target, ghr: pred_ghr};
  assign empty      = (occupancy == '0);
  assign full       = (occupancy == OCC_W'(DEPTH));
  assign stall      = full;
  assign resolve    = res_valid & ~empty;
  assign miss       = resolve & ((res_taken != head.taken) |
                                 (res_taken & head.taken & (res_target != head.target)));
  // A push alongside a mispredict is a younger wrong-path branch and is discarded;
  // a push into a full queue only lands when the head retires cleanly that same edge.
  assign push       = pred_valid & ~miss & (~full | resolve);

  // NOTE: queue storage is deliberately not reset; validity is carried entirely by
  // the pointers and occupancy, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      queue_mem[wr_ptr] <= push_entry;
    end
  end

  // NOTE: all state uses non-blocking assignment so every register sees the pre-edge
  // head entry and occupancy, no matter the statement order below.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      occupancy     <= '0;
      mispredict    <= 1'b0;
      redirect_pc   <= '0;
      restore_ghr   <= '0;
      upd_valid     <= 1'b0;
      upd_index     <= '0;
      upd_taken     <= 1'b0;
      underflow     <= 1'b0;
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      mispredict <= miss;
      upd_valid  <= resolve;

      if (resolve) begin
        upd_index <= head.ghr;
        upd_taken <= res_taken;
        br_count  <= br_count + CNT_W'(1);
      end

      if (miss) begin
        redirect_pc   <= res_taken ? res_target : head.pc + PC_W'(4);
        restore_ghr   <= {head.ghr[GHR_W-2:0], res_taken};
        mispred_count <= mispred_count + CNT_W'(1);
        rd_ptr        <= '0;
        wr_ptr        <= '0;
        occupancy     <= '0;
      end else begin
        if (resolve) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        occupancy <= occupancy + OCC_W'(push) - OCC_W'(resolve);
      end

      if (res_valid & empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a reference queue model predicts each training
// pulse into a scoreboard that a negedge monitor pops and compares.
module tb_branch_resolve_unit;

  localparam int GHR_W = 8;
  localparam int PC_W  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pred_valid = 1'b0;
  logic             pred_taken = 1'b0;
  logic [PC_W-1:0]  pred_pc = '0;
  logic [PC_W-1:0]  pred_target = '0;
  logic [GHR_W-1:0] pred_ghr = '0;
  logic             res_valid = 1'b0;
  logic             res_taken = 1'b0;
  logic [PC_W-1:0]  res_target = '0;
  logic             stall;
  logic             mispredict;
  logic [PC_W-1:0]  redirect_pc;
  logic [GHR_W-1:0] restore_ghr;
  logic             upd_valid;
  logic [GHR_W-1:0] upd_index;
  logic             upd_taken;
  logic             underflow;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispred_count;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .GHR_W(GHR_W), .PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc),
    .pred_target(pred_target), .pred_ghr(pred_ghr),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .stall(stall), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .restore_ghr(restore_ghr), .upd_valid(upd_valid), .upd_index(upd_index),
    .upd_taken(upd_taken), .underflow(underflow), .br_count(br_count),
    .mispred_count(mispred_count)
  );

  typedef struct {
    logic             taken;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  target;
    logic [GHR_W-1:0] ghr;
  } pred_t;

  typedef struct {
    int               due;
    logic             miss;
    logic [GHR_W-1:0] idx;
    logic             tkn;
    logic [PC_W-1:0]  rpc;
    logic [GHR_W-1:0] rghr;
  } exp_t;

  pred_t mq[$];
  exp_t  sb[$];
  exp_t  mon_e;
  int    n_checks = 0;
  int    n_errors = 0;
  int    cycle = 0;
  int    pulses = 0;
  int    pulse_mark;
  bit    mon_en = 1'b0;
  int    br_m = 0;
  int    mis_m = 0;
  logic  uf_m = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every upd_valid pulse must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (mon_en) begin
      if (upd_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("upd_unexpected", 64'(upd_valid), 64'(0));
        end else begin
          mon_e = sb.pop_front();
          pulses++;
          check("upd_latency", 64'(cycle), 64'(mon_e.due));
          check("upd_index", 64'(upd_index), 64'(mon_e.idx));
          check("upd_taken", 64'(upd_taken), 64'(mon_e.tkn));
          check("mispredict", 64'(mispredict), 64'(mon_e.miss));
          if (mon_e.miss) begin
            check("redirect_pc", 64'(redirect_pc), 64'(mon_e.rpc));
            check("restore_ghr", 64'(restore_ghr), 64'(mon_e.rghr));
          end
        end
      end else begin
        if (sb.size() > 0 && sb[0].due <= cycle) begin
          check("upd_missing", 64'(upd_valid), 64'(1));
          void'(sb.pop_front());
        end
        check("mispredict_alone", 64'(mispredict), 64'(0));
      end
    end
  end

  // One cycle of stimulus; updates the reference queue and returns #1 after the edge.
  task automatic step(input logic pv, input logic pt, input logic [PC_W-1:0] ppc,
                      input logic [PC_W-1:0] ptgt, input logic [GHR_W-1:0] pghr,
                      input logic rv, input logic rt, input logic [PC_W-1:0] rtgt);
    pred_t e;
    exp_t  x;
    logic  was_full;
    logic  resolved;
    logic  miss;
    @(negedge clk);
    check("stall", 64'(stall), 64'(mq.size() == DEPTH));
    pred_valid  = pv;
    pred_taken  = pt;
    pred_pc     = ppc;
    pred_target = ptgt;
    pred_ghr    = pghr;
    res_valid   = rv;
    res_taken   = rt;
    res_target  = rtgt;
    was_full = (mq.size() == DEPTH);
    resolved = 1'b0;
    miss     = 1'b0;
    if (rv) begin
      if (mq.size() == 0) begin
        uf_m = 1'b1;
      end else begin
        e = mq.pop_front();
        resolved = 1'b1;
        miss = (rt != e.taken) || (rt && e.taken && (rtgt != e.target));
        br_m++;
        x.due  = cycle + 1;
        x.miss = miss;
        x.idx  = e.ghr;
        x.tkn  = rt;
        x.rpc  = rt ? rtgt : e.pc + 32'd4;
        x.rghr = {e.ghr[GHR_W-2:0], rt};
        sb.push_back(x);
        if (miss) begin
          mis_m++;
          mq.delete();
        end
      end
    end
    if (pv && !miss && (!was_full || resolved)) begin
      mq.push_back('{pt, ppc, ptgt, pghr});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic pt, input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt,
                      input logic [GHR_W-1:0] ghr);
    step(1'b1, pt, pc, tgt, ghr, 1'b0, 1'b0, '0);
  endtask

  task automatic resolve(input logic rt, input logic [PC_W-1:0] rtgt);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, rt, rtgt);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_br_count"}, 64'(br_count), 64'(br_m));
    check({tag, "_mispred_count"}, 64'(mispred_count), 64'(mis_m));
    check({tag, "_underflow"}, 64'(underflow), 64'(uf_m));
  endtask

  // Reset for two edges with both request inputs active; every output must read zero.
  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    pred_valid  = 1'b1;
    pred_taken  = 1'b1;
    pred_pc     = 32'h0000_0DEC;
    pred_target = 32'h0000_0BAD;
    pred_ghr    = 8'hC3;
    res_valid   = 1'b1;
    res_taken   = 1'b0;
    res_target  = 32'h0000_0F00;
    sb.delete();
    mq.delete();
    br_m = 0;
    mis_m = 0;
    uf_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    check("rst_stall", 64'(stall), 64'(0));
    check("rst_mispredict", 64'(mispredict), 64'(0));
    check("rst_redirect_pc", 64'(redirect_pc), 64'(0));
    check("rst_restore_ghr", 64'(restore_ghr), 64'(0));
    check("rst_upd_valid", 64'(upd_valid), 64'(0));
    check("rst_upd_index", 64'(upd_index), 64'(0));
    check("rst_upd_taken", 64'(upd_taken), 64'(0));
    check_counters("rst");
    @(negedge clk);
    rst_n      = 1'b1;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "simulation did not terminate");
  end

  initial begin
    // Reset with active inputs
    do_reset();

    // Correct not-taken
    push(1'b0, 32'h100, 32'h0, 8'h5A);
    resolve(1'b0, 32'h0);
    check("t2_upd_valid", 64'(upd_valid), 64'(1));
    check("t2_upd_index", 64'(upd_index), 64'h5A);
    check("t2_upd_taken", 64'(upd_taken), 64'(0));
    check("t2_mispredict", 64'(mispredict), 64'(0));
    check("t2_br_count", 64'(br_count), 64'(1));
    idle();
    check("t2_upd_pulse_end", 64'(upd_valid), 64'(0));
    check("t2_upd_index_held", 64'(upd_index), 64'h5A);

    // Direction miss: predicted not-taken, actually taken
    push(1'b0, 32'h200, 32'h0, 8'h81);
    resolve(1'b1, 32'h340);
    check("t3_mispredict", 64'(mispredict), 64'(1));
    check("t3_redirect_pc", 64'(redirect_pc), 64'h340);
    check("t3_restore_ghr", 64'(restore_ghr), 64'h03);
    check("t3_mispred_count", 64'(mispred_count), 64'(1));
    idle();
    check("t3_mispredict_pulse_end", 64'(mispredict), 64'(0));
    check("t3_redirect_held", 64'(redirect_pc), 64'h340);

    // Predicted taken, actually not taken: fall through to pc+4
    push(1'b1, 32'h80, 32'h90, 8'h33);
    resolve(1'b0, 32'h0);
    check("t4a_redirect_pc", 64'(redirect_pc), 64'h84);
    check("t4a_restore_ghr", 64'(restore_ghr), 64'h66);
    // Taken both ways but wrong target
    push(1'b1, 32'h80, 32'h90, 8'h10);
    resolve(1'b1, 32'hA0);
    check("t4b_mispredict", 64'(mispredict), 64'(1));
    check("t4b_redirect_pc", 64'(redirect_pc), 64'hA0);
    check("t4b_restore_ghr", 64'(restore_ghr), 64'h21);
    // Taken with matching target is a hit
    push(1'b1, 32'h80, 32'h90, 8'h44);
    resolve(1'b1, 32'h90);
    check("t4c_mispredict", 64'(mispredict), 64'(0));
    idle();
    check_counters("t4");

    // Fill, drop on full, swap while full, then flush with a concurrent push
    push(1'b0, 32'h400, 32'h0, 8'h10);
    push(1'b0, 32'h404, 32'h0, 8'h11);
    push(1'b0, 32'h408, 32'h0, 8'h12);
    push(1'b0, 32'h40C, 32'h0, 8'h13);
    check("t5_stall_full", 64'(stall), 64'(1));
    push(1'b0, 32'h500, 32'h0, 8'h55);
    check("t5_stall_after_drop", 64'(stall), 64'(1));
    step(1'b1, 1'b1, 32'h600, 32'h640, 8'h66, 1'b1, 1'b0, 32'h0);
    check("t5_stall_after_swap", 64'(stall), 64'(1));
    resolve(1'b0, 32'h0);
    resolve(1'b0, 32'h0);
    resolve(1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h700, 32'h0, 8'h77, 1'b1, 1'b0, 32'h0);
    check("t5_flush_mispredict", 64'(mispredict), 64'(1));
    check("t5_flush_redirect_pc", 64'(redirect_pc), 64'h604);
    check("t5_flush_restore_ghr", 64'(restore_ghr), 64'hCC);
    check("t5_stall_after_flush", 64'(stall), 64'(0));
    resolve(1'b1, 32'h0);
    check("t5_underflow", 64'(underflow), 64'(1));
    check("t5_no_upd_on_empty", 64'(upd_valid), 64'(0));
    idle();
    idle();
    check_counters("t5");

    // Reset with entries in flight: nothing survives
    push(1'b1, 32'h800, 32'h900, 8'hA1);
    push(1'b0, 32'h804, 32'h0, 8'hA2);
    do_reset();
    idle();
    resolve(1'b0, 32'h0);
    check("t_midrst_underflow", 64'(underflow), 64'(1));
    idle();
    check_counters("t_midrst");

    // Twelve alternating T/NT branches, pipelined push+resolve, all correct
    do_reset();
    pulse_mark = pulses;
    push(1'b1, 32'h1000, 32'h1040, 8'h00);
    for (int i = 1; i < 12; i++) begin
      step(1'b1, logic'(i % 2 == 0), 32'h1000 + 32'(i * 8), 32'h1040 + 32'(i * 8),
           8'(i * 17), 1'b1, logic'((i - 1) % 2 == 0), 32'h1040 + 32'((i - 1) * 8));
    end
    resolve(1'b0, 32'h1040 + 32'(11 * 8));
    idle();
    idle();
    check("t6_br_count", 64'(br_count), 64'(12));
    check("t6_mispred_count", 64'(mispred_count), 64'(0));
    check("t6_upd_pulses", 64'(pulses - pulse_mark), 64'(12));
    check_counters("t6");

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
